// File: rtl/serial_patdet_pkg.sv
// Shared types and defaults for the serial pattern detector: FSM state enum,
// default geometry and the saturating counter increment.
package serial_patdet_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } patdet_state_e;

  localparam int          DEF_PATTERN_W = 4;
  localparam logic [15:0] DEF_PATTERN   = 16'h000B;
  localparam int          DEF_CNT_W     = 8;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out history register: newest bit enters at the LSB.
// Synchronous clear wins over shift; asynchronous active-low reset.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (shift_en) begin
      q_d = {q_q[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects PATTERN in the accepted serial stream, pulsing match for one cycle.
// Define SERIAL_PATDET_NONOVERLAP_EN to stop matched bits being reused.
module serial_pattern_detector
  import serial_patdet_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clear,
  output logic                 match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [PATTERN_W-1:0] history
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [31:0]       CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  patdet_state_e        state_d, state_q;
  logic [FILL_W-1:0]    fill_d, fill_q;
  logic                 match_d, match_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [PATTERN_W-1:0] hist_next;
  logic [FILL_W-1:0]    fill_inc;
  logic                 accept;
  logic                 hit;

  sipo_shift_reg #(
    .WIDTH (PATTERN_W)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst),
    .shift_en (accept),
    .clear    (clear),
    .din      (din),
    .q        (history),
    .q_next   (hist_next)
  );

  assign accept   = din_valid && !clear;
  assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  // A hit needs a completely valid window, so partial fills never match.
  assign hit      = accept && (hist_next == PATTERN) && (fill_inc == FILL_FULL);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    if (clear) begin
      state_d = FILL;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (accept) begin
      fill_d = fill_inc;
      if (fill_inc == FILL_FULL) begin
        state_d = ARMED;
      end
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
`ifdef SERIAL_PATDET_NONOVERLAP_EN
        fill_d  = '0;
        state_d = FILL;
`else
        state_d = ARMED;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: default 1011 detector, a 2-bit
// counter variant and a 2'b11 variant all share one input stream.
module tb_serial_pattern_detector;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       clear;

  logic       m_match;
  logic [7:0] m_cnt;
  logic [3:0] m_hist;
  logic       s_match;
  logic [1:0] s_cnt;
  logic [3:0] s_hist;
  logic       p_match;
  logic [7:0] p_cnt;
  logic [1:0] p_hist;

  int checks;
  int failures;

  serial_pattern_detector u_main (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .match(m_match), .match_cnt(m_cnt), .history(m_hist)
  );

  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .match(s_match), .match_cnt(s_cnt), .history(s_hist)
  );

  serial_pattern_detector #(.PATTERN_W(2), .PATTERN(2'b11), .CNT_W(8)) u_p11 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .match(p_match), .match_cnt(p_cnt), .history(p_hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic c);
    din_valid = v;
    din       = b;
    clear     = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    #12;
    checks++;
    if (m_match !== 1'b0 || m_cnt !== 8'd0 || m_hist !== 4'd0) begin
      failures++;
      $display("FAIL reset_main: match=%b cnt=%0d hist=%b want 0/0/0000", m_match, m_cnt, m_hist);
    end
    checks++;
    if (s_cnt !== 2'd0 || p_hist !== 2'd0 || p_match !== 1'b0) begin
      failures++;
      $display("FAIL reset_variants: s_cnt=%0d p_hist=%b p_match=%b want 0", s_cnt, p_hist, p_match);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_guard;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b0 || p_match !== 1'b0) begin
      failures++;
      $display("FAIL fill_bit1: m_match=%b p_match=%b want 0/0", m_match, p_match);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b0 || m_hist !== 4'b0011) begin
      failures++;
      $display("FAIL fill_guard: match=%b hist=%b want 0/0011", m_match, m_hist);
    end
    checks++;
    if (p_match !== 1'b1) begin
      failures++;
      $display("FAIL p11_first: match=%b want 1", p_match);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (p_match !== 1'b1 || p_cnt !== 8'd2) begin
      failures++;
      $display("FAIL p11_b2b: match=%b cnt=%0d want 1/2", p_match, p_cnt);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (p_match !== 1'b0 || p_cnt !== 8'd2) begin
      failures++;
      $display("FAIL p11_idle: match=%b cnt=%0d want 0/2", p_match, p_cnt);
    end
  endtask

  task automatic test_overlap;
    logic bits [7];
    logic expm [7];
    logic [7:0] exp_cnt;
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SERIAL_PATDET_NONOVERLAP_EN
    expm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_cnt = 8'd1;
`else
    expm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_cnt = 8'd2;
`endif
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (m_cnt !== 8'd0 || m_hist !== 4'd0 || m_match !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: cnt=%0d hist=%b match=%b want 0", m_cnt, m_hist, m_match);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[i], 1'b0);
      checks++;
      if (m_match !== expm[i]) begin
        failures++;
        $display("FAIL overlap_bit%0d: match=%b want %b", i + 1, m_match, expm[i]);
      end
    end
    checks++;
    if (m_cnt !== exp_cnt || m_hist !== 4'b1011) begin
      failures++;
      $display("FAIL overlap_end: cnt=%0d hist=%b want %0d/1011", m_cnt, m_hist, exp_cnt);
    end
  endtask

  task automatic test_gaps_clear;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (m_match !== 1'b0 || m_hist !== 4'b0010) begin
        failures++;
        $display("FAIL gap%0d: match=%b hist=%b want 0/0010", i, m_match, m_hist);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b0) begin
      failures++;
      $display("FAIL gap_bit3: match=%b want 0", m_match);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b1 || m_cnt !== 8'd1 || m_hist !== 4'b1011) begin
      failures++;
      $display("FAIL gap_match: match=%b cnt=%0d hist=%b want 1/1/1011", m_match, m_cnt, m_hist);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (m_match !== 1'b0 || m_cnt !== 8'd0 || m_hist !== 4'd0) begin
      failures++;
      $display("FAIL clear_valid: match=%b cnt=%0d hist=%b want 0/0/0000", m_match, m_cnt, m_hist);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b0 || m_hist !== 4'b0101) begin
      failures++;
      $display("FAIL post_clear3: match=%b hist=%b want 0/0101", m_match, m_hist);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b1 || m_cnt !== 8'd1) begin
      failures++;
      $display("FAIL post_clear4: match=%b cnt=%0d want 1/1", m_match, m_cnt);
    end
  endtask

  task automatic test_saturation;
    logic pat [4];
    logic [1:0] exp_s;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, pat[i], 1'b0);
        checks++;
        if (s_match !== (i == 3)) begin
          failures++;
          $display("FAIL sat_match r%0d b%0d: match=%b want %b", r, i, s_match, (i == 3));
        end
      end
      exp_s = (r < 3) ? 2'(r + 1) : 2'd3;
      checks++;
      if (s_cnt !== exp_s || m_cnt !== 8'(r + 1)) begin
        failures++;
        $display("FAIL sat_cnt r%0d: s_cnt=%0d m_cnt=%0d want %0d/%0d", r, s_cnt, m_cnt, exp_s, r + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    checks++;
    if (m_cnt !== 8'd0 || s_cnt !== 2'd0 || m_hist !== 4'd0 || m_match !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: m_cnt=%0d s_cnt=%0d hist=%b match=%b want 0", m_cnt, s_cnt, m_hist, m_match);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (m_match !== 1'b0 || m_hist !== 4'b0001) begin
      failures++;
      $display("FAIL rst_single: match=%b hist=%b want 0/0001", m_match, m_hist);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b0);
      checks++;
      if (m_match !== (i == 3)) begin
        failures++;
        $display("FAIL rst_full_b%0d: match=%b want %b", i, m_match, (i == 3));
      end
    end
    checks++;
    if (m_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rst_cnt: cnt=%0d want 1", m_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_guard();
    test_back_to_back();
    test_overlap();
    test_gaps_clear();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Consumes the registered serial bit stream produced by the master-slave D flip-flop stage and detects a fixed PATTERN_W-bit sequence in it. Each accepted bit is shifted into a history register. A one-cycle `match` pulse is raised whenever the last PATTERN_W accepted bits equal PATTERN. A saturating match counter is exposed for status readback.

## Interface
- PATTERN_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, target sequence; MSB is the oldest bit
- CNT_W, 8, match counter width
- clk  input  1  rising-edge clock, shared with the upstream flip-flop stage
- rst  input  1  asynchronous, active-low reset
- din  input  1  serial bit (upstream `q`)
- din_valid  input  1  din is sampled on this edge when high
- clear  input  1  synchronous flush of history, fill state and counter
- match  output  1  one-cycle pulse: pattern completed by the last accepted bit
- match_cnt  output  CNT_W  saturating count of matches
- history  output  PATTERN_W  last accepted bits, newest in LSB

## Operation
- Reset (rst=0, asynchronous): history=0, fill count=0, state=FILL, match=0, match_cnt=0.
- FSM, 2 states:
  - FILL: fewer than PATTERN_W bits accepted since reset, clear or (macro) last match; match never asserts.
  - ARMED: the history is fully valid.
  - FILL→ARMED on the edge that accepts bit number PATTERN_W.
  - ARMED→FILL on clear, or on a match when SERIAL_PATDET_NONOVERLAP_EN is defined.
- Accept (din_valid=1, clear=0): history <= {history[PATTERN_W-2:0], din}; the fill count increments, saturating at PATTERN_W.
- Match condition: the new history equals PATTERN, and the new fill count equals PATTERN_W.
- Counter: match_cnt increments on each match and saturates at 2^CNT_W-1 (no wrap).
- clear=1: history=0, fill=0, state=FILL, match_cnt=0, match=0. clear has priority over din_valid on the same edge; that bit is discarded.
- din_valid=0: all state holds and match returns to 0. Gaps between valid bits do not break a sequence.

## Timing
- Latency: a bit accepted at edge N raises match from edge N until edge N+1. Pulse width is exactly one cycle unless the bit accepted at N+1 also completes a match.
- match_cnt and history update on the same edge as match.
- Back-to-back valid bits produce matches on consecutive cycles when the pattern allows it (e.g. PATTERN=2'b11).
- rst asserted mid-sequence: all outputs clear immediately (asynchronous). Detection restarts in FILL after rst deasserts; the first edge after deassertion may accept a bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_PATDET_NONOVERLAP_EN:
  - Defined: a match resets the fill count to 0 and enters FILL, so bits of a matched sequence are never reused. history still shifts normally.
  - Undefined (default): overlapping detection; the FSM stays in ARMED after a match.

## Structure
- Package `serial_patdet_pkg` holds:
  - the state enum {FILL, ARMED}
  - the default PATTERN_W, PATTERN and CNT_W constants
  - a sat_inc function for the counter
- Sub-module `sipo_shift_reg` (parameterised width, shift enable, sync clear, async active-low reset) implements the history register. The top level holds the FSM, fill counter, compare and match counter.

## Test plan
- Overlap (macro undefined, PATTERN=1011): valid bits 1,0,1,1,0,1,1 → match pulses after bits 4 and 7; match_cnt=2; history=4'b1011.
- Non-overlap (macro defined): same stream → one match after bit 4; match_cnt=1; no match after bit 7, because only 3 bits follow the first match.
- Gaps and clear: bits 1,0 then din_valid=0 for 5 cycles, then 1,1 → match. Next, assert clear together with din_valid=1 → match_cnt=0, history=0, the bit is discarded, and a following 1,0,1,1 matches only after all 4 new bits.
- Saturation (CNT_W=2): stream 1011 repeated 5× non-overlapping → match_cnt goes 1,2,3,3,3; match still pulses each time.
- Fill guard: right after reset, bits 1,1 with PATTERN_W=4 → no match; history=4'b0011.
- Reset mid-operation: after accepting 1,0,1, drive rst low for one cycle → match_cnt=0 immediately; a subsequent single 1 does not match, while a full 1,0,1,1 does.
